// File: rtl/hs32_flagunit.sv
// hs32 execute-side flag unit: holds NZCV, evaluates condition codes against committed flags,
// gates writeback/flag update on the result and registers the outcome in a one-slot output stage.
module hs32_flagunit #(
  parameter int         RW    = 4,
  parameter logic [3:0] FLRST = 4'b0000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [3:0]    i_cond,
  input  logic [31:0]   i_res,
  input  logic [3:0]    i_fl,
  input  logic          i_setfl,
  input  logic          i_wb,
  input  logic [RW-1:0] i_rd,
  input  logic          i_flw,
  input  logic [3:0]    i_flwd,
  output logic [3:0]    o_fl,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [31:0]   o_res,
  output logic [RW-1:0] o_rd,
  output logic          o_wb,
  output logic          o_exec
);

  localparam logic [3:0] C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
                         C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
                         C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
                         C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] fl);
    logic n, z, c, v;
    {n, z, c, v} = fl;
    case (cond)
      C_EQ:    cond_pass = z;
      C_NE:    cond_pass = !z;
      C_CS:    cond_pass = c;
      C_CC:    cond_pass = !c;
      C_MI:    cond_pass = n;
      C_PL:    cond_pass = !n;
      C_VS:    cond_pass = v;
      C_VC:    cond_pass = !v;
      C_HI:    cond_pass = c && !z;
      C_LS:    cond_pass = !c || z;
      C_GE:    cond_pass = (n == v);
      C_LT:    cond_pass = (n != v);
      C_GT:    cond_pass = !z && (n == v);
      C_LE:    cond_pass = z || (n != v);
      C_AL:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;  // NV
    endcase
  endfunction

  logic accept;
  logic pass;

  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready;
  // Evaluated against the committed flags only; a beat never sees its own flag update.
  assign pass    = cond_pass(i_cond, o_fl);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_fl    <= FLRST;
      o_valid <= 1'b0;
      o_res   <= '0;
      o_rd    <= '0;
      o_wb    <= 1'b0;
      o_exec  <= 1'b0;
    end else begin
      if (accept) begin
        o_valid <= 1'b1;
        o_res   <= i_res;
        o_rd    <= i_rd;
        o_exec  <= pass;
        o_wb    <= i_wb && pass;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      // Direct flag writes override any same-cycle ALU flag update.
      if (i_flw)
        o_fl <= i_flwd;
      else if (accept && pass && i_setfl)
        o_fl <= i_fl;
    end
  end

endmodule

// File: tb/tb_hs32_flagunit.sv
// Self-checking bench for hs32_flagunit: scoreboard of expected output beats plus
// per-scenario tasks checking flags, handshake and condition evaluation.
module tb_hs32_flagunit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_valid, o_ready;
  logic [3:0]  i_cond;
  logic [31:0] i_res;
  logic [3:0]  i_fl;
  logic        i_setfl, i_wb;
  logic [3:0]  i_rd;
  logic        i_flw;
  logic [3:0]  i_flwd;
  logic [3:0]  o_fl;
  logic        o_valid, i_ready;
  logic [31:0] o_res;
  logic [3:0]  o_rd;
  logic        o_wb, o_exec;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  rd;
    logic        wb;
    logic        exec;
  } beat_t;

  beat_t      sb[$];
  beat_t      mon_exp;
  logic [3:0] mdl_fl;
  int         checks   = 0;
  int         failures = 0;

  hs32_flagunit #(.RW(4), .FLRST(4'b0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_cond(i_cond), .i_res(i_res), .i_fl(i_fl), .i_setfl(i_setfl),
    .i_wb(i_wb), .i_rd(i_rd), .i_flw(i_flw), .i_flwd(i_flwd),
    .o_fl(o_fl), .o_valid(o_valid), .i_ready(i_ready),
    .o_res(o_res), .o_rd(o_rd), .o_wb(o_wb), .o_exec(o_exec)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Condition reference: even codes test a base predicate, odd codes its inverse.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = ~(n ^ v);
      3'd6: base = ~z & ~(n ^ v);
      default: base = 1'b1;
    endcase
    return c[0] ? ~base : base;
  endfunction

  // Scoreboard comparator: every output transfer must match the oldest expected beat.
  always @(posedge clk) begin
    if (reset_n && o_valid && i_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_beat got res=%h rd=%h wb=%b exec=%b expected none",
                 o_res, o_rd, o_wb, o_exec);
      end else begin
        mon_exp = sb.pop_front();
        if (o_res !== mon_exp.res || o_rd !== mon_exp.rd ||
            o_wb !== mon_exp.wb || o_exec !== mon_exp.exec) begin
          failures++;
          $display("FAIL sb_beat got res=%h rd=%h wb=%b exec=%b expected res=%h rd=%h wb=%b exec=%b",
                   o_res, o_rd, o_wb, o_exec, mon_exp.res, mon_exp.rd, mon_exp.wb, mon_exp.exec);
        end
      end
    end
  end

  // Drives one beat starting at a negedge, waits (bounded) for acceptance, ends at the next negedge.
  task automatic send(input logic [3:0] cond, input logic setfl, input logic [3:0] fl,
                      input logic [31:0] res, input logic wb, input logic [3:0] rd,
                      input logic flw, input logic [3:0] flwd);
    int    n;
    beat_t e;
    logic  p;
    i_valid = 1'b1; i_cond = cond; i_setfl = setfl; i_fl = fl;
    i_res = res; i_wb = wb; i_rd = rd; i_flw = flw; i_flwd = flwd;
    n = 0;
    #1;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
      #1;
    end
    if (!o_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout o_ready=%b expected 1", o_ready);
      i_valid = 1'b0; i_flw = 1'b0;
      return;
    end
    p = ref_cond(cond, mdl_fl);
    e.res = res; e.rd = rd; e.wb = wb & p; e.exec = p;
    sb.push_back(e);
    if (flw) mdl_fl = flwd;
    else if (p && setfl) mdl_fl = fl;
    @(negedge clk);
    i_valid = 1'b0; i_flw = 1'b0;
  endtask

  task automatic set_flags(input logic [3:0] v);
    i_flw = 1'b1; i_flwd = v;
    @(negedge clk);
    i_flw = 1'b0;
    mdl_fl = v;
    checks++;
    if (o_fl !== v) begin
      failures++;
      $display("FAIL set_flags o_fl=%b expected %b", o_fl, v);
    end
  endtask

  task automatic wait_drain();
    int n;
    i_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || o_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain pending=%0d o_valid=%b expected 0 and 0", sb.size(), o_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_valid = 1'b1; i_flw = 1'b1; i_flwd = 4'b1111; i_ready = 1'b1;
    i_cond = 4'hE; i_setfl = 1'b1; i_fl = 4'b1111; i_res = 32'hdead; i_wb = 1'b1; i_rd = 4'h7;
    repeat (3) @(negedge clk);
    reset_n = 1'b1; i_valid = 1'b0; i_flw = 1'b0;
    mdl_fl = 4'b0000;
    #1;
    checks++;
    if (o_fl !== 4'b0000) begin failures++; $display("FAIL reset_fl o_fl=%b expected 0000", o_fl); end
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid o_valid=%b expected 0", o_valid); end
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready o_ready=%b expected 1", o_ready); end
    checks++;
    if (o_res !== 32'h0 || o_rd !== 4'h0 || o_wb !== 1'b0 || o_exec !== 1'b0) begin
      failures++;
      $display("FAIL reset_outs res=%h rd=%h wb=%b exec=%b expected all 0", o_res, o_rd, o_wb, o_exec);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    send(4'hE, 1'b1, 4'b0100, 32'd5, 1'b1, 4'd3, 1'b0, 4'b0000);
    checks++;
    if (o_valid !== 1'b1 || o_res !== 32'd5 || o_rd !== 4'd3 || o_wb !== 1'b1 || o_exec !== 1'b1) begin
      failures++;
      $display("FAIL basic_beat valid=%b res=%h rd=%h wb=%b exec=%b expected 1 5 3 1 1",
               o_valid, o_res, o_rd, o_wb, o_exec);
    end
    checks++;
    if (o_fl !== 4'b0100) begin failures++; $display("FAIL basic_fl o_fl=%b expected 0100", o_fl); end
  endtask

  task automatic test_cond_gate();
    send(4'h1, 1'b1, 4'b0010, 32'h11, 1'b1, 4'd4, 1'b0, 4'b0000);
    checks++;
    if (o_exec !== 1'b0 || o_wb !== 1'b0 || o_valid !== 1'b1) begin
      failures++;
      $display("FAIL ne_fail valid=%b exec=%b wb=%b expected 1 0 0", o_valid, o_exec, o_wb);
    end
    checks++;
    if (o_fl !== 4'b0100) begin failures++; $display("FAIL ne_fl o_fl=%b expected 0100", o_fl); end
    send(4'h0, 1'b0, 4'b0000, 32'h22, 1'b1, 4'd5, 1'b0, 4'b0000);
    checks++;
    if (o_exec !== 1'b1 || o_wb !== 1'b1) begin
      failures++;
      $display("FAIL eq_pass exec=%b wb=%b expected 1 1", o_exec, o_wb);
    end
  endtask

  task automatic test_backpressure();
    beat_t e;
    wait_drain();
    i_ready = 1'b0;
    send(4'hE, 1'b0, 4'b0000, 32'hAAAA_0001, 1'b1, 4'd8, 1'b0, 4'b0000);
    // Second beat held at the input while downstream stalls.
    i_valid = 1'b1; i_cond = 4'hE; i_setfl = 1'b0; i_res = 32'hBBBB_0002; i_wb = 1'b1; i_rd = 4'd9;
    repeat (2) begin
      #1;
      checks++;
      if (o_ready !== 1'b0 || o_res !== 32'hAAAA_0001 || o_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall ready=%b res=%h valid=%b expected 0 aaaa0001 1", o_ready, o_res, o_valid);
      end
      @(negedge clk);
    end
    i_ready = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL release_ready o_ready=%b expected 1", o_ready); end
    e.res = 32'hBBBB_0002; e.rd = 4'd9; e.wb = 1'b1; e.exec = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    i_valid = 1'b0;
    checks++;
    if (o_res !== 32'hBBBB_0002 || o_valid !== 1'b1) begin
      failures++;
      $display("FAIL second_beat res=%h valid=%b expected bbbb0002 1", o_res, o_valid);
    end
    wait_drain();
  endtask

  task automatic test_flw_priority();
    send(4'hE, 1'b1, 4'b1000, 32'h33, 1'b1, 4'd1, 1'b1, 4'b0011);
    checks++;
    if (o_fl !== 4'b0011) begin failures++; $display("FAIL flw_prio o_fl=%b expected 0011", o_fl); end
    // Z is clear in the old flags, so EQ must fail even though the direct write sets Z.
    send(4'h0, 1'b0, 4'b0000, 32'h44, 1'b1, 4'd2, 1'b1, 4'b0100);
    checks++;
    if (o_exec !== 1'b0 || o_fl !== 4'b0100) begin
      failures++;
      $display("FAIL flw_old_cond exec=%b fl=%b expected 0 0100", o_exec, o_fl);
    end
  endtask

  task automatic test_signed();
    logic [3:0] cs[6] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hF, 4'hF};
    logic [3:0] fs[6] = '{4'b1001, 4'b1001, 4'b1000, 4'b1000, 4'b1001, 4'b0100};
    logic       es[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      set_flags(fs[i]);
      send(cs[i], 1'b0, 4'b0000, 32'h100 + i, 1'b1, 4'(i), 1'b0, 4'b0000);
      checks++;
      if (o_exec !== es[i]) begin
        failures++;
        $display("FAIL signed_cond cond=%h fl=%b exec=%b expected %b", cs[i], fs[i], o_exec, es[i]);
      end
    end
  endtask

  task automatic test_all_conds();
    for (int c = 0; c < 16; c++) begin
      for (int k = 0; k < 3; k++) begin
        set_flags(4'($urandom_range(0, 15)));
        send(4'(c), 1'b0, 4'b0000, $urandom, 1'($urandom_range(0, 1)), 4'(c), 1'b0, 4'b0000);
      end
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      send(4'($urandom_range(0, 15)), 1'b1, 4'($urandom_range(0, 15)), $urandom,
           1'b1, 4'($urandom_range(0, 15)), 1'b0, 4'b0000);
      checks++;
      if (o_fl !== mdl_fl) begin
        failures++;
        $display("FAIL b2b_fl beat=%0d o_fl=%b expected %b", i, o_fl, mdl_fl);
      end
    end
    wait_drain();
  endtask

  initial begin
    reset_n = 1'b0; i_valid = 1'b0; i_flw = 1'b0; i_ready = 1'b1;
    i_cond = 4'h0; i_res = '0; i_fl = '0; i_setfl = 1'b0; i_wb = 1'b0; i_rd = '0; i_flwd = '0;
    mdl_fl = 4'b0000;
    @(negedge clk);
    test_reset();
    test_basic();
    test_cond_gate();
    test_backpressure();
    test_flw_priority();
    test_signed();
    test_all_conds();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
